// File: rtl/nash_rx_sequencer.sv
// Nash cipher stream receiver: a rule-30 field evolves D steps per block to make keystream; ct ^ keystream -> pt.
// Latency: seed -> first ct_ready takes D+1 cycles; ct handshake -> pt_valid the next cycle; at most one block per D+1 cycles.
// Backpressure: one-entry output register; ct_ready stays low while pt is held or a seed is offered; evolution continues meanwhile.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   seed_valid/seed_ready/seed      seed handshake (key-management side)
//   ct_valid/ct_ready/ct_data       ciphertext in (link deframer side)
//   pt_valid/pt_ready/pt_data       plaintext out (consumer side)
//   busy                            high while the field is evolving
//   blocks_done                     plaintext blocks handed off, wraps at 2^32
module nash_rx_sequencer #(
    parameter int N = 128,
    parameter int D = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_valid,
    output logic         seed_ready,
    input  logic [N-1:0] seed,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [N-1:0] ct_data,
    output logic         pt_valid,
    input  logic         pt_ready,
    output logic [N-1:0] pt_data,
    output logic         busy,
    output logic [31:0]  blocks_done
);

    localparam int CW = $clog2(D + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVOLVE = 2'd1,
        KEY    = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  field;
    logic [CW-1:0] cnt;

    logic          load_seed;
    logic          step_field;
    logic          take_ct;

    // One rule-30 generation with wrap-around neighbours:
    // right neighbour F[i+1] is a rotate-right, left neighbour F[i-1] a rotate-left.
    function automatic logic [N-1:0] rule30_step(input logic [N-1:0] f);
        return {f[0], f[N-1:1]} ^ (f | {f[N-2:0], f[N-1]});
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        ct_ready   = 1'b0;
        busy       = 1'b0;
        load_seed  = 1'b0;
        step_field = 1'b0;
        take_ct    = 1'b0;
        case (state)
            IDLE: begin
                seed_ready = 1'b1;
                if (seed_valid) begin
                    load_seed = 1'b1;
                    state_nxt = EVOLVE;
                end
            end
            EVOLVE: begin
                busy       = 1'b1;
                step_field = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = KEY;
                end
            end
            KEY: begin
                // A pending seed wins over ciphertext, and nothing moves
                // until the output register has drained.
                seed_ready = !pt_valid;
                ct_ready   = !pt_valid && !seed_valid;
                if (seed_valid && !pt_valid) begin
                    load_seed = 1'b1;
                    state_nxt = EVOLVE;
                end else if (ct_valid && !pt_valid && !seed_valid) begin
                    take_ct   = 1'b1;
                    state_nxt = EVOLVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Field and step counter. After a ct block the field keeps evolving from
    // the spent keystream, so consecutive blocks share one continuous stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            field <= '0;
            cnt   <= '0;
        end else if (load_seed) begin
            field <= seed;
            cnt   <= '0;
        end else if (step_field) begin
            field <= rule30_step(field);
            cnt   <= cnt + CW'(1);
        end else if (take_ct) begin
            cnt   <= '0;
        end
    end

    // Output register. take_ct only fires with pt_valid low, so load and
    // drain never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pt_valid    <= 1'b0;
            pt_data     <= '0;
            blocks_done <= '0;
        end else begin
            if (take_ct) begin
                pt_valid <= 1'b1;
                pt_data  <= ct_data ^ field;
            end else if (pt_valid && pt_ready) begin
                pt_valid <= 1'b0;
            end
            if (pt_valid && pt_ready) begin
                blocks_done <= blocks_done + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_nash_rx_sequencer.sv
// Bench for nash_rx_sequencer: three instances (N=8/D=1, N=8/D=4, N=128/D=256).
// Directed table on the D=1 instance, hand-written corner sequences on D=4,
// randomized flow-controlled traffic against a software rule-30 model on the default size.
module tb_nash_rx_sequencer;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: N=8, D=1 ----------------
    logic        a_seed_valid, a_seed_ready, a_ct_valid, a_ct_ready, a_pt_valid, a_pt_ready, a_busy;
    logic [7:0]  a_seed_d, a_ct_d, a_pt_d;
    logic [31:0] a_blocks;

    nash_rx_sequencer #(.N(8), .D(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(a_seed_valid), .seed_ready(a_seed_ready), .seed(a_seed_d),
        .ct_valid(a_ct_valid), .ct_ready(a_ct_ready), .ct_data(a_ct_d),
        .pt_valid(a_pt_valid), .pt_ready(a_pt_ready), .pt_data(a_pt_d),
        .busy(a_busy), .blocks_done(a_blocks)
    );

    // ---------------- instance B: N=8, D=4 ----------------
    logic        b_seed_valid, b_seed_ready, b_ct_valid, b_ct_ready, b_pt_valid, b_pt_ready, b_busy;
    logic [7:0]  b_seed_d, b_ct_d, b_pt_d;
    logic [31:0] b_blocks;

    nash_rx_sequencer #(.N(8), .D(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(b_seed_valid), .seed_ready(b_seed_ready), .seed(b_seed_d),
        .ct_valid(b_ct_valid), .ct_ready(b_ct_ready), .ct_data(b_ct_d),
        .pt_valid(b_pt_valid), .pt_ready(b_pt_ready), .pt_data(b_pt_d),
        .busy(b_busy), .blocks_done(b_blocks)
    );

    // ---------------- instance C: defaults ----------------
    logic          c_seed_valid, c_seed_ready, c_ct_valid, c_ct_ready, c_pt_valid, c_pt_ready, c_busy;
    logic [127:0]  c_seed_d, c_ct_d, c_pt_d;
    logic [31:0]   c_blocks;

    nash_rx_sequencer u_c (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(c_seed_valid), .seed_ready(c_seed_ready), .seed(c_seed_d),
        .ct_valid(c_ct_valid), .ct_ready(c_ct_ready), .ct_data(c_ct_d),
        .pt_valid(c_pt_valid), .pt_ready(c_pt_ready), .pt_data(c_pt_d),
        .busy(c_busy), .blocks_done(c_blocks)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Software rule-30: F'[i] = F[(i+1)%n] ^ (F[i] | F[(i-1)%n]), applied 'steps' times.
    function automatic logic [127:0] evolve(input logic [127:0] f0, input int n, input int steps);
        logic [127:0] f, g;
        logic [6:0]   ii, ip, im;
        f = f0;
        for (int s = 0; s < steps; s++) begin
            g = '0;
            for (int i = 0; i < n; i++) begin
                ii = 7'(i);
                ip = 7'((i + 1) % n);
                im = 7'((i + n - 1) % n);
                g[ii] = f[ip] ^ (f[ii] | f[im]);
            end
            f = g;
        end
        return f;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- instance A helpers ----------------
    int a_expected_blocks;

    task automatic a_seed_hs(input logic [7:0] d);
        int n;
        a_seed_d = d; a_seed_valid = 1'b1; #1;
        n = 0;
        while (!a_seed_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("a_seed_wait_timeout", 1, 0);
        @(posedge clk); #1;
        a_seed_valid = 1'b0;
        // seed handshake at edge t: busy in t+1, ct_ready first in t+2
        chk("a_busy_after_seed", a_busy, 1);
        chk("a_ct_ready_t1", a_ct_ready, 0);
        @(posedge clk); #1;
        chk("a_ct_ready_t2", a_ct_ready, 1);
        chk("a_busy_t2", a_busy, 0);
    endtask

    task automatic a_ct_hs(input logic [7:0] d, input logic [7:0] exp);
        int n;
        a_ct_d = d; a_ct_valid = 1'b1; #1;
        n = 0;
        while (!a_ct_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("a_ct_wait_timeout", 1, 0);
        @(posedge clk); #1;
        a_ct_valid = 1'b0;
        chk("a_pt_valid", a_pt_valid, 1);
        chk("a_pt_data", a_pt_d, exp);
        a_pt_ready = 1'b1;
        @(posedge clk); #1;
        a_pt_ready = 1'b0;
        a_expected_blocks++;
        chk("a_blocks_done", a_blocks, a_expected_blocks);
        chk("a_pt_valid_cleared", a_pt_valid, 0);
    endtask

    // ---------------- instance B helpers ----------------
    task automatic b_seed_hs(input logic [7:0] d);
        int n;
        b_seed_d = d; b_seed_valid = 1'b1; #1;
        n = 0;
        while (!b_seed_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("b_seed_wait_timeout", 1, 0);
        @(posedge clk); #1;
        b_seed_valid = 1'b0;
    endtask

    task automatic b_ct_hs(input logic [7:0] d);
        int n;
        b_ct_d = d; b_ct_valid = 1'b1; #1;
        n = 0;
        while (!b_ct_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) chk("b_ct_wait_timeout", 1, 0);
        @(posedge clk); #1;
        b_ct_valid = 1'b0;
    endtask

    typedef struct {
        logic       is_seed;
        logic [7:0] dat;
        logic [7:0] exp_pt;
    } vec_t;

    vec_t vecs[10];

    localparam int NBLK  = 150;
    localparam int CD    = 256;
    localparam int LIMIT = 80000;

    initial begin
        logic [7:0] k4;
        n_cmp = 0; n_bad = 0; a_expected_blocks = 0;

        // Hand-computed N=8/D=1 vectors. Keystream after seed 01 is 83, then 46, then ED;
        // seed 80 gives C1; seed FF gives 00.
        vecs[0] = '{1'b1, 8'h01, 8'h00};
        vecs[1] = '{1'b0, 8'hFF, 8'h7C};
        vecs[2] = '{1'b0, 8'h00, 8'h46};
        vecs[3] = '{1'b0, 8'h0F, 8'hE2};
        vecs[4] = '{1'b1, 8'h80, 8'h00};
        vecs[5] = '{1'b0, 8'hC1, 8'h00};
        vecs[6] = '{1'b1, 8'hFF, 8'h00};
        vecs[7] = '{1'b0, 8'h5A, 8'h5A};
        vecs[8] = '{1'b1, 8'h01, 8'h00};
        vecs[9] = '{1'b0, 8'h00, 8'h83};

        rst_n = 1'b0;
        a_seed_valid = 0; a_ct_valid = 0; a_pt_ready = 0; a_seed_d = '0; a_ct_d = '0;
        b_seed_valid = 0; b_ct_valid = 0; b_pt_ready = 0; b_seed_d = '0; b_ct_d = '0;
        c_seed_valid = 0; c_ct_valid = 0; c_pt_ready = 0; c_seed_d = '0; c_ct_d = '0;
        #2;
        chk("rst_seed_ready", b_seed_ready, 1);
        chk("rst_ct_ready", b_ct_ready, 0);
        chk("rst_busy", b_busy, 0);
        chk("rst_pt_valid", b_pt_valid, 0);
        chk("rst_pt_data", b_pt_d, 0);
        chk("rst_blocks", b_blocks, 0);
        chk("rst_c_seed_ready", c_seed_ready, 1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- reset with a block pending and the field mid-evolution (B) ----
        b_seed_hs(8'h01);
        b_ct_hs(8'h00);
        b_pt_ready = 1'b1; @(posedge clk); #1; b_pt_ready = 1'b0;
        chk("b_blocks_pre_rst", b_blocks, 1);
        b_ct_hs(8'h00);
        chk("b_pt_valid_pre_rst", b_pt_valid, 1);
        chk("b_busy_pre_rst", b_busy, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_seed_ready", b_seed_ready, 1);
        chk("mid_rst_ct_ready", b_ct_ready, 0);
        chk("mid_rst_pt_valid", b_pt_valid, 0);
        chk("mid_rst_blocks", b_blocks, 0);
        chk("mid_rst_busy", b_busy, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- directed table (A) ----
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].is_seed) a_seed_hs(vecs[v].dat);
            else                 a_ct_hs(vecs[v].dat, vecs[v].exp_pt);
        end

        // ---- backpressure (B): hold pt_ready low for 20 cycles ----
        k4 = 8'(evolve(128'h01, 8, 4));
        b_seed_hs(8'h01);
        b_ct_hs(8'h00);
        for (int j = 1; j <= 20; j++) begin
            chk("bp_pt_valid", b_pt_valid, 1);
            chk("bp_pt_data", b_pt_d, k4);
            chk("bp_ct_ready", b_ct_ready, 0);
            chk("bp_busy", b_busy, (j <= 4) ? 1 : 0);
            if (j < 20) begin @(posedge clk); #1; end
        end
        b_pt_ready = 1'b1; @(posedge clk); #1; b_pt_ready = 1'b0;
        chk("bp_blocks_once", b_blocks, 1);
        chk("bp_pt_valid_clear", b_pt_valid, 0);
        chk("bp_ct_ready_after", b_ct_ready, 1);
        @(posedge clk); #1;
        chk("bp_blocks_stable", b_blocks, 1);

        // ---- reseed priority (B): seed and ct offered together in KEY ----
        b_seed_d = 8'h80; b_seed_valid = 1'b1; b_ct_d = 8'h33; b_ct_valid = 1'b1; #1;
        chk("rs_ct_ready_blocked", b_ct_ready, 0);
        chk("rs_seed_ready", b_seed_ready, 1);
        @(posedge clk); #1;
        b_seed_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            chk("rs_busy", b_busy, 1);
            chk("rs_ct_ignored", b_ct_ready, 0);
            chk("rs_no_pt", b_pt_valid, 0);
            @(posedge clk); #1;
        end
        chk("rs_busy_done", b_busy, 0);
        chk("rs_ct_ready", b_ct_ready, 1);
        @(posedge clk); #1;
        b_ct_valid = 1'b0;
        chk("rs_pt_valid", b_pt_valid, 1);
        chk("rs_pt_data", b_pt_d, 8'h33 ^ 8'(evolve(128'h80, 8, 4)));
        chk("rs_blocks", b_blocks, 1);
        b_pt_ready = 1'b1; @(posedge clk); #1; b_pt_ready = 1'b0;
        chk("rs_blocks_after", b_blocks, 2);

        // ---- randomized traffic against the model (C) ----
        begin
            logic [127:0] km, seed_hold, ct_hold, exp_pt;
            logic [127:0] q[$];
            logic seed_hs, ct_hs, pt_hs;
            int cyc, taken, sent, last_ct, last_seed;
            cyc = 0; taken = 0; sent = 0; last_ct = -1; last_seed = -1;
            km = '0;
            c_seed_d = rand128(); c_seed_valid = 1'b1;
            while (taken < NBLK && cyc < LIMIT) begin
                if (!c_seed_valid && $urandom_range(0, 2999) == 0) begin
                    c_seed_d = rand128(); c_seed_valid = 1'b1;
                end
                c_ct_valid = ($urandom_range(0, 3) != 0);
                c_ct_d     = rand128();
                c_pt_ready = ($urandom_range(0, 1) != 0);
                #1;
                seed_hs   = c_seed_valid && c_seed_ready;
                ct_hs     = c_ct_valid && c_ct_ready;
                pt_hs     = c_pt_valid && c_pt_ready;
                seed_hold = c_seed_d;
                ct_hold   = c_ct_d;
                chk("c_pt_valid_model", c_pt_valid, (q.size() != 0) ? 1 : 0);
                if (pt_hs && q.size() != 0) begin
                    exp_pt = q.pop_front();
                    chk("c_pt_data", c_pt_d, exp_pt);
                    taken++;
                end
                if (ct_hs) begin
                    if (last_ct >= 0) chk("c_ct_spacing", (cyc - last_ct >= CD + 1) ? 1 : 0, 1);
                    if (last_seed >= 0) chk("c_seed_to_ct", (cyc - last_seed >= CD + 1) ? 1 : 0, 1);
                    q.push_back(ct_hold ^ km);
                    km = evolve(km, 128, CD);
                    last_ct = cyc;
                    sent++;
                end
                if (seed_hs) begin
                    km = evolve(seed_hold, 128, CD);
                    last_seed = cyc;
                end
                @(posedge clk); cyc++; #1;
                if (seed_hs) c_seed_valid = 1'b0;
            end
            c_ct_valid = 1'b0; c_seed_valid = 1'b0; c_pt_ready = 1'b0;
            chk("c_all_blocks_taken", taken, NBLK);
            chk("c_no_dup_or_loss", sent, taken);
            chk("c_queue_empty", q.size(), 0);
            chk("c_blocks_done", c_blocks, taken);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
